// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the bus sequencer.
package bus_pkg;

  localparam int DEFAULT_BUS_WIDTH = 16;
  localparam int DEFAULT_NUM_REGS  = 4;
  localparam int DEFAULT_SEL_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_INC   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/bidi_register.sv
// Loadable bus register with tri-state bus port, increment strobe and preset load.
module bidi_register #(
  parameter int WIDTH = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             rw,
  input  logic             count,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  inout  wire  [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge CLOCK) begin
    if (!RESET)              value <= '0;
    else if (load)           value <= load_value;
    else if (enable && !rw)  value <= data;
    else if (count)          value <= value + 1'b1;
  end

  assign data = (enable && rw) ? value : 'z;

endmodule

// File: rtl/bus_sel_decode.sv
// Register index to one-hot decode; valid is low when the index has no register.
module bus_sel_decode
  import bus_pkg::*;
#(
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [NUM_REGS-1:0]  onehot,
  output logic                 valid
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[i] = (sel == SEL_WIDTH'(i));
  end

  // An out-of-range index matches no bit.
  assign valid = |onehot;

endmodule

// File: rtl/bus_sequencer.sv
// Register-to-register transfer sequencer over a shared tri-state bus.
// Optional immediate sourcing is enabled by defining SEQ_IMM_SRC_EN.
// Handshake: REQ is sampled only in IDLE; ACK (with ERR on rejection) pulses for one cycle in DONE.
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
  input  logic                 RESET,
  input  logic                 CLOCK,
  input  logic                 REQ,
  input  logic [SEL_WIDTH-1:0] SRC_SEL,
  input  logic [SEL_WIDTH-1:0] DST_SEL,
  input  logic                 INC,
  input  logic                 IMM_SEL,
  input  logic [BUS_WIDTH-1:0] IMM,
  output logic                 BUSY,
  output logic                 ACK,
  output logic                 ERR,
  output logic [NUM_REGS-1:0]  REG_ENABLE,
  output logic [NUM_REGS-1:0]  REG_RW,
  output logic [NUM_REGS-1:0]  REG_COUNT,
  output logic [BUS_WIDTH-1:0] LAST_DATA,
  inout  wire  [BUS_WIDTH-1:0] DATA,
  output logic [2:0]           STATE
);

  seq_state_t          state;
  logic [NUM_REGS-1:0] src_dec, dst_dec, src_oh, dst_oh;
  logic                src_ok, dst_ok, inc_l, imm_l, imm_drive, reject;

  bus_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) u_src_dec (
    .sel(SRC_SEL), .onehot(src_dec), .valid(src_ok)
  );
  bus_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) u_dst_dec (
    .sel(DST_SEL), .onehot(dst_dec), .valid(dst_ok)
  );

`ifdef SEQ_IMM_SRC_EN
  logic [BUS_WIDTH-1:0] imm_q;

  assign reject = !src_ok || !dst_ok || (!IMM_SEL && (SRC_SEL == DST_SEL));

  // The immediate is captured with the request so later IMM changes cannot disturb the bus.
  always_ff @(posedge CLOCK) begin
    if (state == ST_IDLE && REQ) imm_q <= IMM;
  end

  assign DATA = imm_drive ? imm_q : 'z;
`else
  logic [BUS_WIDTH:0] unused_imm;

  assign reject     = !src_ok || !dst_ok || IMM_SEL || (SRC_SEL == DST_SEL);
  assign unused_imm = {IMM, imm_drive};
  assign DATA       = 'z;
`endif

  assign STATE = state;

  // Outputs are registered alongside the state they belong to, so each state's
  // bus controls are visible for exactly the cycle the FSM occupies it.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      BUSY       <= 1'b0;
      ACK        <= 1'b0;
      ERR        <= 1'b0;
      REG_ENABLE <= '0;
      REG_RW     <= '0;
      REG_COUNT  <= '0;
      LAST_DATA  <= '0;
      src_oh     <= '0;
      dst_oh     <= '0;
      inc_l      <= 1'b0;
      imm_l      <= 1'b0;
      imm_drive  <= 1'b0;
    end else begin
      BUSY       <= 1'b1;
      ACK        <= 1'b0;
      ERR        <= 1'b0;
      REG_ENABLE <= '0;
      REG_RW     <= '0;
      REG_COUNT  <= '0;
      imm_drive  <= 1'b0;
      case (state)
        ST_IDLE: begin
          BUSY <= 1'b0;
          if (REQ) begin
            BUSY   <= 1'b1;
            src_oh <= src_dec;
            dst_oh <= dst_dec;
            inc_l  <= INC;
            imm_l  <= IMM_SEL;
            if (reject) begin
              state <= ST_DONE;
              ACK   <= 1'b1;
              ERR   <= 1'b1;
            end else begin
              state      <= ST_SETUP;
              REG_ENABLE <= IMM_SEL ? '0 : src_dec;
              REG_RW     <= IMM_SEL ? '0 : src_dec;
              imm_drive  <= IMM_SEL;
            end
          end
        end
        ST_SETUP: begin
          state      <= ST_XFER;
          REG_ENABLE <= (imm_l ? '0 : src_oh) | dst_oh;
          REG_RW     <= imm_l ? '0 : src_oh;
          imm_drive  <= imm_l;
        end
        ST_XFER: begin
          LAST_DATA <= DATA;
          if (inc_l && !imm_l) begin
            state     <= ST_INC;
            REG_COUNT <= src_oh;
          end else begin
            state <= ST_DONE;
            ACK   <= 1'b1;
          end
        end
        ST_INC: begin
          state <= ST_DONE;
          ACK   <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer driving four bidi_register instances on the shared bus.
module tb_bus_sequencer;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  logic reg_rst_n = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic         REQ = 1'b0, INC = 1'b0, IMM_SEL = 1'b0;
  logic [S-1:0] SRC_SEL = '0, DST_SEL = '0;
  logic [W-1:0] IMM = '0;
  logic         BUSY, ACK, ERR;
  logic [N-1:0] REG_ENABLE, REG_RW, REG_COUNT;
  logic [W-1:0] LAST_DATA;
  logic [2:0]   STATE;
  wire  [W-1:0] DATA;

  logic         reg_load = 1'b0;
  logic [W-1:0] reg_init [N];
  logic [W-1:0] r_val [N];

  bus_sequencer #(.BUS_WIDTH(W), .NUM_REGS(N), .SEL_WIDTH(S)) dut (
    .RESET(RESET), .CLOCK(CLOCK), .REQ(REQ), .SRC_SEL(SRC_SEL), .DST_SEL(DST_SEL),
    .INC(INC), .IMM_SEL(IMM_SEL), .IMM(IMM), .BUSY(BUSY), .ACK(ACK), .ERR(ERR),
    .REG_ENABLE(REG_ENABLE), .REG_RW(REG_RW), .REG_COUNT(REG_COUNT),
    .LAST_DATA(LAST_DATA), .DATA(DATA), .STATE(STATE)
  );

  for (genvar g = 0; g < N; g++) begin : g_reg
    bidi_register #(.WIDTH(W)) u_reg (
      .CLOCK(CLOCK), .RESET(reg_rst_n), .enable(REG_ENABLE[g]), .rw(REG_RW[g]),
      .count(REG_COUNT[g]), .load(reg_load), .load_value(reg_init[g]),
      .data(DATA), .value(r_val[g])
    );
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  src;
    logic [1:0]  dst;
    logic        inc;
    logic        imm_sel;
    logic [15:0] imm;
    logic [15:0] src_val;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic [3:0]            lat;
    logic                  err;
    logic [W-1:0]          last;
    logic [N-1:0][W-1:0]   regs;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mdl [N];
  logic [W-1:0] mdl_last;
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Only one register may drive the bus in any cycle.
  always @(negedge CLOCK) begin
    if (RESET) check("single_driver", 32'($countones(REG_ENABLE & REG_RW) <= 1), 32'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic preset(input logic [W-1:0] v0, v1, v2, v3);
    reg_init[0] = v0; reg_init[1] = v1; reg_init[2] = v2; reg_init[3] = v3;
    reg_load = 1'b1;
    @(posedge CLOCK); @(negedge CLOCK);
    reg_load = 1'b0;
    mdl[0] = v0; mdl[1] = v1; mdl[2] = v2; mdl[3] = v3;
  endtask

  task automatic run_req(input vec_t v);
    exp_t         e;
    logic [W-1:0] bg [N];
    logic [N-1:0] en_acc;
    logic         got_err;
    int           lat;
    for (int i = 0; i < N; i++) bg[i] = 16'hA000 + 16'(i);
    bg[v.src] = v.src_val;
    preset(bg[0], bg[1], bg[2], bg[3]);
    if (!v.exp_err) begin
      mdl[v.dst] = v.imm_sel ? v.imm : mdl[v.src];
      mdl_last   = mdl[v.dst];
      if (v.inc && !v.imm_sel) mdl[v.src] = mdl[v.src] + 16'd1;
    end
    e.lat  = 4'(v.exp_lat);
    e.err  = v.exp_err;
    e.last = mdl_last;
    for (int i = 0; i < N; i++) e.regs[i] = mdl[i];
    exp_q.push_back(e);

    SRC_SEL = v.src; DST_SEL = v.dst; INC = v.inc; IMM_SEL = v.imm_sel; IMM = v.imm;
    REQ = 1'b1;
    en_acc = '0; lat = 0; got_err = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLOCK); @(negedge CLOCK);
      if (n == 1) begin
        // Scramble inputs while busy; they must not affect the transfer.
        REQ = 1'b0;
        SRC_SEL = S'($urandom_range(0, 3)); DST_SEL = S'($urandom_range(0, 3));
        INC = 1'($urandom_range(0, 1)); IMM_SEL = 1'($urandom_range(0, 1));
        IMM = W'($urandom);
      end
      en_acc |= REG_ENABLE;
      if (ACK) begin
        lat = n;
        got_err = ERR;
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    check("ack_latency", 32'(lat), 32'(e.lat));
    check("err", 32'(got_err), 32'(e.err));
    check("last_data", 32'(LAST_DATA), 32'(e.last));
    for (int i = 0; i < N; i++) check($sformatf("reg%0d", i), 32'(r_val[i]), 32'(e.regs[i]));
    if (e.err) check("reject_no_enable", 32'(en_acc), 32'd0);
    @(posedge CLOCK); @(negedge CLOCK);
    check("idle_after_done", 32'(BUSY), 32'd0);
  endtask

  // Reset asserted in SETUP (at_xfer=0) or XFER (at_xfer=1) of a R0 -> R3 transfer.
  task automatic reset_mid(input int at_xfer, input logic [W-1:0] exp_r3);
    logic ack_seen;
    preset(16'hAAAA, 16'hA001, 16'hA002, 16'h5555);
    SRC_SEL = 2'd0; DST_SEL = 2'd3; INC = 1'b0; IMM_SEL = 1'b0;
    REQ = 1'b1;
    @(posedge CLOCK); @(negedge CLOCK);
    REQ = 1'b0;
    if (at_xfer != 0) begin
      @(posedge CLOCK); @(negedge CLOCK);
    end
    RESET = 1'b0;
    @(posedge CLOCK); @(negedge CLOCK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_enable", 32'(REG_ENABLE), 32'd0);
    check("rst_rw", 32'(REG_RW), 32'd0);
    check("rst_count", 32'(REG_COUNT), 32'd0);
    check("rst_last_data", 32'(LAST_DATA), 32'd0);
    check("rst_dst", 32'(r_val[3]), 32'(exp_r3));
    check("rst_src", 32'(r_val[0]), 32'hAAAA);
    RESET = 1'b1;
    mdl_last = '0;
    ack_seen = 1'b0;
    repeat (6) begin
      @(posedge CLOCK); @(negedge CLOCK);
      ack_seen |= ACK;
    end
    check("rst_no_ack", 32'(ack_seen), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t       vecs [6];
  logic [7:0] ack_pat, busy_pat;

  initial begin
    for (int i = 0; i < N; i++) reg_init[i] = '0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_ack", 32'(ACK), 32'd0);
    check("reset_err", 32'(ERR), 32'd0);
    check("reset_enable", 32'(REG_ENABLE), 32'd0);
    check("reset_rw", 32'(REG_RW), 32'd0);
    check("reset_count", 32'(REG_COUNT), 32'd0);
    check("reset_last_data", 32'(LAST_DATA), 32'd0);
    RESET = 1'b1;
    reg_rst_n = 1'b1;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    mdl_last = '0;
    @(negedge CLOCK);

    //         src   dst   inc   imm   imm       src_val   err   lat
    vecs[0] = '{2'd1, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0, 3};
    vecs[1] = '{2'd0, 2'd3, 1'b1, 1'b0, 16'h0000, 16'h00FF, 1'b0, 4};
    vecs[2] = '{2'd2, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h3333, 1'b1, 1};
    vecs[3] = '{2'd3, 2'd0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 4};
`ifdef SEQ_IMM_SRC_EN
    vecs[4] = '{2'd0, 2'd1, 1'b1, 1'b1, 16'hBEEF, 16'h7777, 1'b0, 3};
`else
    vecs[4] = '{2'd0, 2'd1, 1'b1, 1'b1, 16'hBEEF, 16'h7777, 1'b1, 1};
`endif
    vecs[5] = '{2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 3};

    for (int k = 0; k < 6; k++) run_req(vecs[k]);

    reset_mid(0, 16'h5555);
    // At the XFER-ending edge the register still sees its load enable, so it loads.
    reset_mid(1, 16'hAAAA);

    // REQ held high: second transfer only after DONE -> IDLE.
    preset(16'h1357, 16'hA001, 16'hA002, 16'hA003);
    SRC_SEL = 2'd0; DST_SEL = 2'd1; INC = 1'b0; IMM_SEL = 1'b0;
    REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLOCK); @(negedge CLOCK);
      ack_pat[i]  = ACK;
      busy_pat[i] = BUSY;
      if (i == 6) REQ = 1'b0;
    end
    check("held_ack_pattern", 32'(ack_pat), 32'h44);
    check("held_busy_pattern", 32'(busy_pat), 32'h77);
    check("held_dst", 32'(r_val[1]), 32'h1357);
    check("held_src", 32'(r_val[0]), 32'h1357);
    check("held_last_data", 32'(LAST_DATA), 32'h1357);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
